// File: rtl/uart_pkg.sv
// Shared UART package: runtime frame configuration, FSM state encoding and
// the parity helper used by both the transmitter and the receiver.
package uart_pkg;

    localparam int UART_OVS = 16;

    typedef struct packed {
        logic [3:0] data_len;      // 5..8
        logic       parity_en;
        logic       parity_even;
        logic [1:0] stop_len;      // 1..2
    } uart_config;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } uart_states;

    // Parity bit that makes the total count of ones even (or odd).
    function automatic logic calc_parity(input logic       parity_en,
                                         input logic       parity_even,
                                         input logic [7:0] bits);
        if (!parity_en)
            return 1'b0;
        return parity_even ? ^bits : ~^bits;
    endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Serial input synchronizer; with UART_RX_MAJORITY_EN defined it also forms
// the 2-of-3 vote of the synchronized line over ticks OVS/2-2 .. OVS/2.
module uart_rx_sync
    import uart_pkg::*;
#(
    parameter int OVS = UART_OVS
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       pls_rx,
    input  logic [3:0] ovscnt,
    input  logic       rxd,
    output logic       rxd_s,
    output logic       sample
);

    logic [1:0] sync_reg;

    always_ff @(posedge clk) begin
        if (rst)
            sync_reg <= 2'b11;
        else
            sync_reg <= {sync_reg[0], rxd};
    end

    assign rxd_s = sync_reg[1];

`ifdef UART_RX_MAJORITY_EN
    localparam logic [3:0] VOTE_A_TICK = 4'(OVS / 2 - 2);
    localparam logic [3:0] VOTE_B_TICK = 4'(OVS / 2 - 1);

    logic vote_a_reg;
    logic vote_b_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            vote_a_reg <= 1'b1;
            vote_b_reg <= 1'b1;
        end else if (pls_rx) begin
            if (ovscnt == VOTE_A_TICK)
                vote_a_reg <= rxd_s;
            if (ovscnt == VOTE_B_TICK)
                vote_b_reg <= rxd_s;
        end
    end

    // Third vote is the live sample at the decision tick.
    assign sample = (vote_a_reg & vote_b_reg) | (vote_a_reg & rxd_s) | (vote_b_reg & rxd_s);
`else
    logic unused_ok;
    assign unused_ok = ^{pls_rx, ovscnt};
    assign sample    = rxd_s;
`endif

endmodule

// File: rtl/uart_rx.sv
// UART receiver: 16x oversampled frame reassembly with hold/ack handshake.
// Define UART_RX_MAJORITY_EN to sample each bit by 3-tick majority vote.
module uart_rx
    import uart_pkg::*;
#(
    parameter int OVS = UART_OVS
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       pls_rx,
    input  logic       uart_rxd,
    input  uart_config ucfg,
    input  logic       ack_rx,
    output logic [7:0] data,
    output logic       valid_rx,
    output logic       parity_err,
    output logic       frame_err,
    output logic       overrun_err,
    output logic       busy_rx
);

    localparam logic [3:0] LAST_TICK = 4'(OVS - 1);
`ifdef UART_RX_MAJORITY_EN
    localparam logic [3:0] SMP_TICK = 4'(OVS / 2);
`else
    localparam logic [3:0] SMP_TICK = 4'(OVS / 2 - 1);
`endif

    uart_states state_reg;
    logic [3:0] ovscnt_reg;
    logic [3:0] bitcnt_reg;
    logic [7:0] rsr_reg;
    logic       armed_reg;
    logic       perr_frm_reg;
    logic       ferr_frm_reg;
    logic [7:0] data_reg;
    logic       valid_reg;
    logic       parity_err_reg;
    logic       frame_err_reg;
    logic       overrun_reg;

    logic       rxd_s;
    logic       sample;
    logic       smp_now;
    logic       bit_end;
    logic [3:0] last_data;
    logic [3:0] last_stop;
    logic       complete;
    logic       hold;

    uart_rx_sync #(.OVS(OVS)) u_sync (
        .clk    (clk),
        .rst    (rst),
        .pls_rx (pls_rx),
        .ovscnt (ovscnt_reg),
        .rxd    (uart_rxd),
        .rxd_s  (rxd_s),
        .sample (sample)
    );

    assign smp_now   = pls_rx && (ovscnt_reg == SMP_TICK);
    assign bit_end   = pls_rx && (ovscnt_reg == LAST_TICK);
    assign last_data = ucfg.data_len - 4'd1;
    assign last_stop = {2'b00, ucfg.stop_len} - 4'd1;
    // Magnitude compares keep the FSM moving if ucfg changes mid-frame.
    assign complete  = (state_reg == STOP) && smp_now && (bitcnt_reg >= last_stop);
    assign hold      = valid_reg && !ack_rx;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= IDLE;
            ovscnt_reg   <= 4'd0;
            bitcnt_reg   <= 4'd0;
            rsr_reg      <= 8'd0;
            armed_reg    <= 1'b0;
            perr_frm_reg <= 1'b0;
            ferr_frm_reg <= 1'b0;
        end else begin
            if (pls_rx && state_reg != IDLE)
                ovscnt_reg <= ovscnt_reg + 4'd1;
            case (state_reg)
                IDLE: begin
                    if (pls_rx) begin
                        if (rxd_s) begin
                            armed_reg <= 1'b1;
                        end else if (armed_reg) begin
                            state_reg    <= START;
                            ovscnt_reg   <= 4'd0;
                            rsr_reg      <= 8'd0;
                            perr_frm_reg <= 1'b0;
                            ferr_frm_reg <= 1'b0;
                        end
                    end
                end
                START: begin
                    if (smp_now && sample) begin
                        state_reg <= IDLE;
                    end else if (bit_end) begin
                        state_reg  <= DATA;
                        bitcnt_reg <= 4'd0;
                    end
                end
                DATA: begin
                    if (smp_now && !bitcnt_reg[3])
                        rsr_reg[bitcnt_reg[2:0]] <= sample;
                    if (bit_end) begin
                        if (bitcnt_reg >= last_data) begin
                            state_reg  <= ucfg.parity_en ? PARITY : STOP;
                            bitcnt_reg <= 4'd0;
                        end else begin
                            bitcnt_reg <= bitcnt_reg + 4'd1;
                        end
                    end
                end
                PARITY: begin
                    if (smp_now)
                        perr_frm_reg <= (sample != calc_parity(ucfg.parity_en, ucfg.parity_even, rsr_reg));
                    if (bit_end) begin
                        state_reg  <= STOP;
                        bitcnt_reg <= 4'd0;
                    end
                end
                STOP: begin
                    if (smp_now) begin
                        if (!sample)
                            ferr_frm_reg <= 1'b1;
                        // A low final stop bit (break) must see idle high before re-arming.
                        if (bitcnt_reg >= last_stop) begin
                            state_reg <= IDLE;
                            armed_reg <= sample;
                        end
                    end else if (bit_end) begin
                        bitcnt_reg <= bitcnt_reg + 4'd1;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            data_reg       <= 8'd0;
            valid_reg      <= 1'b0;
            parity_err_reg <= 1'b0;
            frame_err_reg  <= 1'b0;
            overrun_reg    <= 1'b0;
        end else begin
            if (ack_rx && valid_reg) begin
                valid_reg   <= 1'b0;
                overrun_reg <= 1'b0;
            end
            // An ack in the same cycle frees the holding register first.
            if (complete) begin
                if (!hold) begin
                    data_reg       <= rsr_reg;
                    parity_err_reg <= perr_frm_reg;
                    frame_err_reg  <= ferr_frm_reg | ~sample;
                    valid_reg      <= 1'b1;
                end else begin
                    overrun_reg <= 1'b1;
                end
            end
        end
    end

    assign data        = data_reg;
    assign valid_rx    = valid_reg;
    assign parity_err  = parity_err_reg;
    assign frame_err   = frame_err_reg;
    assign overrun_err = overrun_reg;
    assign busy_rx     = (state_reg != IDLE);

endmodule
